mem_arbiter: RTL and testbench

- Two-port arbiter in front of the single-ported `memory_interface`.
- Shares it between the instruction-fetch requester (port I, read-only, word) and the load/store requester (port D, byte/half/word, read or write).
- Valid/ready request handshake per port; one transaction outstanding at a time; response routed back to the granted port with a one-cycle valid strobe.

---
 rtl/mem_arbiter_pkg.sv | 55 +++++
 rtl/mem_arbiter_arb_select.sv | 38 +++
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the memory arbiter slice: bus widths, memory
//   access-size and response codes, arbiter port IDs, FSM state encoding
//   and the registered memory-request record.
//   Optional feature macro used by the arbiter: MEM_ARB_RR_EN.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned MEM_COUNT_W = 2;
    localparam int unsigned MEM_CODE_W  = 3;
    localparam int unsigned ARB_ST_W    = 2;

    // Access size presented to memory_interface.
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

    // Response codes returned by memory_interface.
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_NONE         = 3'd0;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ         = 3'd1;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE        = 3'd2;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED   = 3'd3;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_OUT_OF_RANGE = 3'd4;

    typedef enum logic {
        ARB_PORT_IF = 1'b0,
        ARB_PORT_LS = 1'b1
    } arb_port_e;

    typedef enum logic [ARB_ST_W-1:0] {
        ARB_ST_IDLE = 2'd0,
        ARB_ST_MEM  = 2'd1,
        ARB_ST_RSP  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]      addr;
        logic [WORD_W-1:0]      wr_data;
        logic [MEM_COUNT_W-1:0] count;
        logic                   wr_en;
    } mem_req_t;

    // A fetch is always a full-word read with no store data.
    function automatic mem_req_t fetch_req(input logic [ADDR_W-1:0] addr);
        mem_req_t r;
        r.addr    = addr;
        r.wr_data = '0;
        r.count   = MEM_COUNT_WORD;
        r.wr_en   = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// arb_select
//   Combinational grant picker for the two arbiter ports.
//   Ports:
//     i_en        grants may be issued this cycle
//     i_if_valid  fetch port requesting
//     i_ls_valid  load/store port requesting
//     i_ptr       port that wins when both request (ARB_PORT_IF/ARB_PORT_LS)
//     o_if_grant  one-hot grant, fetch port
//     o_ls_grant  one-hot grant, load/store port
module arb_select
    import mem_arbiter_pkg::*;
(
    input  logic i_en,
    input  logic i_if_valid,
    input  logic i_ls_valid,
    input  logic i_ptr,
    output logic o_if_grant,
    output logic o_ls_grant
);

    always_comb begin
        o_if_grant = 1'b0;
        o_ls_grant = 1'b0;
        if (i_en) begin
            if (i_if_valid && i_ls_valid) begin
                if (i_ptr == ARB_PORT_LS) begin
                    o_ls_grant = 1'b1;
                end else begin
                    o_if_grant = 1'b1;
                end
            end else begin
                o_if_grant = i_if_valid;
                o_ls_grant = i_ls_valid;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported memory_interface between the instruction-fetch
//   port (IF, word reads only) and the load/store port (LS, byte/half/word,
//   read or write). One transaction outstanding; accept-to-response is two
//   cycles; the response is a one-cycle strobe on the owning port.
//   Optional feature: define MEM_ARB_RR_EN for round-robin arbitration of
//   contested cycles; otherwise LS has fixed priority over IF.
//   Ports:
//     clk, aresetn                 clock, asynchronous active-low reset
//     i_if_req_* / o_if_req_ready  fetch request handshake
//     o_if_rsp_*                   fetch response (valid strobe, data, code)
//     i_ls_req_* / o_ls_req_ready  load/store request handshake
//     o_ls_rsp_*                   load/store response
//     o_mem_*                      registered request to memory_interface
//     i_mem_rd_data, i_mem_code    memory_interface response
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WORD_COUNT = 128
) (
    input  logic                   clk,
    input  logic                   aresetn,

    input  logic                   i_if_req_valid,
    input  logic [ADDR_W-1:0]      i_if_req_addr,
    output logic                   o_if_req_ready,
    output logic                   o_if_rsp_valid,
    output logic [WORD_W-1:0]      o_if_rsp_data,
    output logic [MEM_CODE_W-1:0]  o_if_rsp_code,

    input  logic                   i_ls_req_valid,
    input  logic [ADDR_W-1:0]      i_ls_req_addr,
    input  logic [WORD_W-1:0]      i_ls_req_wr_data,
    input  logic [MEM_COUNT_W-1:0] i_ls_req_count,
    input  logic                   i_ls_req_wr_en,
    output logic                   o_ls_req_ready,
    output logic                   o_ls_rsp_valid,
    output logic [WORD_W-1:0]      o_ls_rsp_data,
    output logic [MEM_CODE_W-1:0]  o_ls_rsp_code,

    output logic [ADDR_W-1:0]      o_mem_addr,
    output logic [WORD_W-1:0]      o_mem_wr_data,
    output logic [MEM_COUNT_W-1:0] o_mem_count,
    output logic                   o_mem_wr_en,
    input  logic [WORD_W-1:0]      i_mem_rd_data,
    input  logic [MEM_CODE_W-1:0]  i_mem_code
);

    // Depth is only meaningful to the memory instance; reject a nonsense value.
    if (WORD_COUNT == 0) begin : g_word_count_check
        $error("mem_arbiter: WORD_COUNT must be non-zero");
    end

    arb_state_e state_q, state_d;
    arb_port_e  owner_q, owner_d;
    mem_req_t   mem_req_q, mem_req_d;

    logic can_accept;
    logic if_gnt;
    logic ls_gnt;
    logic prio_ptr;

`ifdef MEM_ARB_RR_EN
    arb_port_e ptr_q, ptr_d;
    assign prio_ptr = ptr_q;
`else
    assign prio_ptr = ARB_PORT_LS;
`endif

    // A new request may be taken while idle or in the response cycle.
    assign can_accept = (state_q == ARB_ST_IDLE) || (state_q == ARB_ST_RSP);

    arb_select u_arb_select (
        .i_en       (can_accept),
        .i_if_valid (i_if_req_valid),
        .i_ls_valid (i_ls_req_valid),
        .i_ptr      (prio_ptr),
        .o_if_grant (if_gnt),
        .o_ls_grant (ls_gnt)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        mem_req_d = mem_req_q;
`ifdef MEM_ARB_RR_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            ARB_ST_IDLE, ARB_ST_RSP: begin
                if (ls_gnt) begin
                    state_d   = ARB_ST_MEM;
                    owner_d   = ARB_PORT_LS;
                    mem_req_d = '{addr:    i_ls_req_addr,
                                  wr_data: i_ls_req_wr_data,
                                  count:   i_ls_req_count,
                                  wr_en:   i_ls_req_wr_en};
                end else if (if_gnt) begin
                    state_d   = ARB_ST_MEM;
                    owner_d   = ARB_PORT_IF;
                    mem_req_d = fetch_req(i_if_req_addr);
                end else begin
                    state_d         = ARB_ST_IDLE;
                    mem_req_d.count = MEM_COUNT_NONE;
                    mem_req_d.wr_en = 1'b0;
                end
            end
            ARB_ST_MEM: begin
                // Memory samples the request on this edge; withdraw it so the
                // access is not repeated during the response cycle.
                state_d         = ARB_ST_RSP;
                mem_req_d.count = MEM_COUNT_NONE;
                mem_req_d.wr_en = 1'b0;
            end
            default: begin
                state_d         = ARB_ST_IDLE;
                mem_req_d.count = MEM_COUNT_NONE;
                mem_req_d.wr_en = 1'b0;
            end
        endcase
`ifdef MEM_ARB_RR_EN
        // Only a contested grant moves the pointer, to the losing port.
        if ((if_gnt || ls_gnt) && i_if_req_valid && i_ls_req_valid) begin
            ptr_d = ls_gnt ? ARB_PORT_IF : ARB_PORT_LS;
        end
`endif
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ARB_ST_IDLE;
            owner_q   <= ARB_PORT_LS;
            mem_req_q <= '{addr:    '0,
                           wr_data: '0,
                           count:   MEM_COUNT_NONE,
                           wr_en:   1'b0};
`ifdef MEM_ARB_RR_EN
            ptr_q     <= ARB_PORT_IF;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            mem_req_q <= mem_req_d;
`ifdef MEM_ARB_RR_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    logic rsp_if;
    logic rsp_ls;

    assign rsp_if = (state_q == ARB_ST_RSP) && (owner_q == ARB_PORT_IF);
    assign rsp_ls = (state_q == ARB_ST_RSP) && (owner_q == ARB_PORT_LS);

    assign o_if_req_ready = if_gnt;
    assign o_ls_req_ready = ls_gnt;

    assign o_if_rsp_valid = rsp_if;
    assign o_if_rsp_data  = rsp_if ? i_mem_rd_data : '0;
    assign o_if_rsp_code  = rsp_if ? i_mem_code    : '0;

    assign o_ls_rsp_valid = rsp_ls;
    assign o_ls_rsp_data  = rsp_ls ? i_mem_rd_data : '0;
    assign o_ls_rsp_code  = rsp_ls ? i_mem_code    : '0;

    assign o_mem_addr    = mem_req_q.addr;
    assign o_mem_wr_data = mem_req_q.wr_data;
    assign o_mem_count   = mem_req_q.count;
    assign o_mem_wr_en   = mem_req_q.wr_en;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a behavioural memory_interface
//   (registered response, little-endian byte lanes, alignment and range
//   codes). Table of single transactions plus hand sequences for
//   contention / round-robin, reset during MEM and idle behaviour.
//   Honours MEM_ARB_RR_EN when defined for the build.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned WORD_COUNT = 128;

    logic                   clk;
    logic                   aresetn;
    logic                   if_valid;
    logic [ADDR_W-1:0]      if_addr;
    logic                   if_ready;
    logic                   if_rsp_valid;
    logic [WORD_W-1:0]      if_rsp_data;
    logic [MEM_CODE_W-1:0]  if_rsp_code;
    logic                   ls_valid;
    logic [ADDR_W-1:0]      ls_addr;
    logic [WORD_W-1:0]      ls_wdata;
    logic [MEM_COUNT_W-1:0] ls_cnt;
    logic                   ls_we;
    logic                   ls_ready;
    logic                   ls_rsp_valid;
    logic [WORD_W-1:0]      ls_rsp_data;
    logic [MEM_CODE_W-1:0]  ls_rsp_code;
    logic [ADDR_W-1:0]      mem_addr;
    logic [WORD_W-1:0]      mem_wr_data;
    logic [MEM_COUNT_W-1:0] mem_count;
    logic                   mem_wr_en;
    logic [WORD_W-1:0]      mem_rd_data;
    logic [MEM_CODE_W-1:0]  mem_code;

    mem_arbiter #(.WORD_COUNT(WORD_COUNT)) dut (
        .clk              (clk),
        .aresetn          (aresetn),
        .i_if_req_valid   (if_valid),
        .i_if_req_addr    (if_addr),
        .o_if_req_ready   (if_ready),
        .o_if_rsp_valid   (if_rsp_valid),
        .o_if_rsp_data    (if_rsp_data),
        .o_if_rsp_code    (if_rsp_code),
        .i_ls_req_valid   (ls_valid),
        .i_ls_req_addr    (ls_addr),
        .i_ls_req_wr_data (ls_wdata),
        .i_ls_req_count   (ls_cnt),
        .i_ls_req_wr_en   (ls_we),
        .o_ls_req_ready   (ls_ready),
        .o_ls_rsp_valid   (ls_rsp_valid),
        .o_ls_rsp_data    (ls_rsp_data),
        .o_ls_rsp_code    (ls_rsp_code),
        .o_mem_addr       (mem_addr),
        .o_mem_wr_data    (mem_wr_data),
        .o_mem_count      (mem_count),
        .o_mem_wr_en      (mem_wr_en),
        .i_mem_rd_data    (mem_rd_data),
        .i_mem_code       (mem_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory_interface: samples whenever count != NONE.
    logic [31:0] mem_words [WORD_COUNT] = '{default: '0};
    initial begin
        mem_rd_data = '0;
        mem_code    = MEM_CODE_NONE;
    end
    always @(posedge clk) begin : mem_model
        logic [31:0] w;
        logic [1:0]  off;
        int          idx;
        if (mem_count != MEM_COUNT_NONE) begin
            off = mem_addr[1:0];
            if (mem_addr >= WORD_COUNT * 4) begin
                mem_rd_data <= '0;
                mem_code    <= MEM_CODE_OUT_OF_RANGE;
            end else if ((mem_count == MEM_COUNT_HALF && off[0]) ||
                         (mem_count == MEM_COUNT_WORD && off != 2'd0)) begin
                mem_rd_data <= '0;
                mem_code    <= MEM_CODE_MISALIGNED;
            end else begin
                idx = int'(mem_addr[31:2]);
                w   = mem_words[idx];
                if (mem_wr_en) begin
                    case (mem_count)
                        MEM_COUNT_BYTE: w[8*off +: 8]  = mem_wr_data[7:0];
                        MEM_COUNT_HALF: w[8*off +: 16] = mem_wr_data[15:0];
                        default:        w              = mem_wr_data;
                    endcase
                    mem_words[idx] <= w;
                    mem_rd_data    <= '0;
                    mem_code       <= MEM_CODE_WRITE;
                end else begin
                    w = w >> (8 * off);
                    case (mem_count)
                        MEM_COUNT_BYTE: mem_rd_data <= {24'h0, w[7:0]};
                        MEM_COUNT_HALF: mem_rd_data <= {16'h0, w[15:0]};
                        default:        mem_rd_data <= w;
                    endcase
                    mem_code <= MEM_CODE_READ;
                end
            end
        end
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_ls;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  cnt;
        logic        we;
        logic [31:0] exp_data;
        logic [2:0]  exp_code;
    } vec_t;

    function automatic vec_t mk(input logic is_ls, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [1:0] cnt,
                                input logic we, input logic [31:0] exp_data,
                                input logic [2:0] exp_code);
        vec_t v;
        v.is_ls = is_ls; v.addr = addr; v.wdata = wdata; v.cnt = cnt;
        v.we = we; v.exp_data = exp_data; v.exp_code = exp_code;
        return v;
    endfunction

    // One transaction on an otherwise idle arbiter: accept on first cycle,
    // request visible on o_mem_* in MEM, response strobe two cycles later.
    task automatic run_vec(input vec_t v, input string tag);
        bit got;
        int waited;
        @(negedge clk);
        if (v.is_ls) begin
            ls_valid = 1'b1; ls_addr = v.addr; ls_wdata = v.wdata;
            ls_cnt = v.cnt; ls_we = v.we;
        end else begin
            if_valid = 1'b1; if_addr = v.addr;
        end
        got = 1'b0;
        waited = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (v.is_ls ? ls_ready : if_ready) begin
                got = 1'b1;
                waited = c;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_accept"}, 32'(got), 32'd1);
        if (!got) begin
            if_valid = 1'b0;
            ls_valid = 1'b0;
            return;
        end
        chk({tag, "_wait"}, 32'(waited), 32'd0);
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        ls_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_mem_addr"}, mem_addr, v.addr);
        chk({tag, "_mem_count"}, 32'(mem_count), v.is_ls ? 32'(v.cnt) : 32'(MEM_COUNT_WORD));
        chk({tag, "_mem_we"}, 32'(mem_wr_en), v.is_ls ? 32'(v.we) : 32'd0);
        chk({tag, "_mem_wdata"}, mem_wr_data, v.is_ls ? v.wdata : 32'd0);
        chk({tag, "_early_rsp"}, {30'd0, if_rsp_valid, ls_rsp_valid}, 32'd0);
        @(negedge clk);
        if (v.is_ls) begin
            chk({tag, "_rsp_valid"}, 32'(ls_rsp_valid), 32'd1);
            chk({tag, "_rsp_data"}, ls_rsp_data, v.exp_data);
            chk({tag, "_rsp_code"}, 32'(ls_rsp_code), 32'(v.exp_code));
            chk({tag, "_other_valid"}, 32'(if_rsp_valid), 32'd0);
            chk({tag, "_other_data"}, if_rsp_data | 32'(if_rsp_code), 32'd0);
        end else begin
            chk({tag, "_rsp_valid"}, 32'(if_rsp_valid), 32'd1);
            chk({tag, "_rsp_data"}, if_rsp_data, v.exp_data);
            chk({tag, "_rsp_code"}, 32'(if_rsp_code), 32'(v.exp_code));
            chk({tag, "_other_valid"}, 32'(ls_rsp_valid), 32'd0);
            chk({tag, "_other_data"}, ls_rsp_data | 32'(ls_rsp_code), 32'd0);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[16];

    initial begin : main
        int n_g;
        int last_c;
        int n_if_rsp;
        int n_ls_rsp;

        vecs[0]  = mk(1, 32'h010, 32'hdeadbeef, MEM_COUNT_WORD, 1, 32'h0,        MEM_CODE_WRITE);
        vecs[1]  = mk(0, 32'h010, 32'h0,        MEM_COUNT_WORD, 0, 32'hdeadbeef, MEM_CODE_READ);
        vecs[2]  = mk(1, 32'h004, 32'h11223344, MEM_COUNT_WORD, 1, 32'h0,        MEM_CODE_WRITE);
        vecs[3]  = mk(1, 32'h006, 32'h0badf00d, MEM_COUNT_WORD, 1, 32'h0,        MEM_CODE_MISALIGNED);
        vecs[4]  = mk(1, 32'h004, 32'h0,        MEM_COUNT_WORD, 0, 32'h11223344, MEM_CODE_READ);
        vecs[5]  = mk(1, 32'h005, 32'h0,        MEM_COUNT_BYTE, 0, 32'h00000033, MEM_CODE_READ);
        vecs[6]  = mk(1, 32'h006, 32'h0,        MEM_COUNT_HALF, 0, 32'h00001122, MEM_CODE_READ);
        vecs[7]  = mk(1, 32'h007, 32'h0,        MEM_COUNT_HALF, 0, 32'h0,        MEM_CODE_MISALIGNED);
        vecs[8]  = mk(1, 32'h012, 32'hffffbeef, MEM_COUNT_HALF, 1, 32'h0,        MEM_CODE_WRITE);
        vecs[9]  = mk(0, 32'h010, 32'h0,        MEM_COUNT_WORD, 0, 32'hbeefbeef, MEM_CODE_READ);
        vecs[10] = mk(1, 32'h011, 32'h0000005a, MEM_COUNT_BYTE, 1, 32'h0,        MEM_CODE_WRITE);
        vecs[11] = mk(1, 32'h011, 32'h0,        MEM_COUNT_BYTE, 0, 32'h0000005a, MEM_CODE_READ);
        vecs[12] = mk(1, 32'h200, 32'h0,        MEM_COUNT_WORD, 0, 32'h0,        MEM_CODE_OUT_OF_RANGE);
        vecs[13] = mk(0, 32'h1fc, 32'h0,        MEM_COUNT_WORD, 0, 32'h0,        MEM_CODE_READ);
        vecs[14] = mk(0, 32'h010, 32'h0,        MEM_COUNT_WORD, 0, 32'hbeef5aef, MEM_CODE_READ);
        vecs[15] = mk(0, 32'h002, 32'h0,        MEM_COUNT_WORD, 0, 32'h0,        MEM_CODE_MISALIGNED);

        aresetn = 1'b0;
        if_valid = 1'b0; if_addr = '0;
        ls_valid = 1'b0; ls_addr = '0; ls_wdata = '0; ls_cnt = MEM_COUNT_NONE; ls_we = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_count", 32'(mem_count), 32'(MEM_COUNT_NONE));
        chk("rst_mem_we", 32'(mem_wr_en), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wr_data, 32'd0);
        chk("rst_ready", {30'd0, if_ready, ls_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, if_rsp_valid, ls_rsp_valid}, 32'd0);
        chk("rst_rsp_data", if_rsp_data | ls_rsp_data, 32'd0);
        chk("rst_rsp_code", 32'(if_rsp_code) | 32'(ls_rsp_code), 32'd0);
        aresetn = 1'b1;

`ifdef MEM_ARB_RR_EN
        // Both ports valid continuously: grants alternate IF, LS, ...
        @(negedge clk);
        if_valid = 1'b1; if_addr = 32'h0;
        ls_valid = 1'b1; ls_addr = 32'h3; ls_cnt = MEM_COUNT_BYTE; ls_we = 1'b0; ls_wdata = '0;
        n_g = 0; last_c = 0; n_if_rsp = 0; n_ls_rsp = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (if_rsp_valid) begin
                n_if_rsp++;
                chk("rr_if_code", 32'(if_rsp_code), 32'(MEM_CODE_READ));
            end
            if (ls_rsp_valid) begin
                n_ls_rsp++;
                chk("rr_ls_code", 32'(ls_rsp_code), 32'(MEM_CODE_READ));
            end
            if (n_g < 8 && (if_ready || ls_ready)) begin
                chk($sformatf("rr_grant%0d", n_g), 32'(ls_ready), 32'(n_g % 2));
                chk($sformatf("rr_onehot%0d", n_g), 32'(if_ready & ls_ready), 32'd0);
                if (n_g > 0) chk($sformatf("rr_gap%0d", n_g), 32'(c - last_c), 32'd2);
                last_c = c;
                n_g++;
                if (n_g == 8) begin
                    @(posedge clk);
                    #1;
                    if_valid = 1'b0;
                    ls_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        chk("rr_grants", 32'(n_g), 32'd8);
        chk("rr_if_rsps", 32'(n_if_rsp), 32'd4);
        chk("rr_ls_rsps", 32'(n_ls_rsp), 32'd4);
`else
        // Simultaneous requests: LS first, IF taken in LS's response cycle.
        n_g = 0; last_c = 0; n_if_rsp = 0; n_ls_rsp = 0;
        @(negedge clk);
        if_valid = 1'b1; if_addr = 32'h0;
        ls_valid = 1'b1; ls_addr = 32'h3; ls_wdata = 32'h000000a5;
        ls_cnt = MEM_COUNT_BYTE; ls_we = 1'b1;
        #1;
        chk("cont_ls_ready", 32'(ls_ready), 32'd1);
        chk("cont_if_held", 32'(if_ready), 32'd0);
        @(posedge clk);
        #1;
        ls_valid = 1'b0;
        @(negedge clk);
        chk("cont_mem_ready", {30'd0, if_ready, ls_ready}, 32'd0);
        @(negedge clk);
        chk("cont_ls_rsp_valid", 32'(ls_rsp_valid), 32'd1);
        chk("cont_ls_rsp_code", 32'(ls_rsp_code), 32'(MEM_CODE_WRITE));
        chk("cont_ls_rsp_data", ls_rsp_data, 32'd0);
        chk("cont_if_ready_rsp", 32'(if_ready), 32'd1);
        chk("cont_if_rsp_quiet", 32'(if_rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        @(negedge clk);
        chk("cont_mem2_rsp", {30'd0, if_rsp_valid, ls_rsp_valid}, 32'd0);
        @(negedge clk);
        chk("cont_if_rsp_valid", 32'(if_rsp_valid), 32'd1);
        chk("cont_if_rsp_data", if_rsp_data, 32'ha5000000);
        chk("cont_if_rsp_code", 32'(if_rsp_code), 32'(MEM_CODE_READ));
        chk("cont_ls_rsp_quiet", 32'(ls_rsp_valid), 32'd0);
`endif

        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Reset while the store sits in MEM: it must never reach memory.
        @(negedge clk);
        ls_valid = 1'b1; ls_addr = 32'h20; ls_wdata = 32'hcafef00d;
        ls_cnt = MEM_COUNT_WORD; ls_we = 1'b1;
        #1;
        chk("rstmid_accept", 32'(ls_ready), 32'd1);
        @(posedge clk);
        #1;
        ls_valid = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        chk("rstmid_count", 32'(mem_count), 32'(MEM_COUNT_NONE));
        chk("rstmid_we", 32'(mem_wr_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rstmid_rsp%0d", i), {30'd0, if_rsp_valid, ls_rsp_valid}, 32'd0);
        end
        aresetn = 1'b1;
        run_vec(mk(1, 32'h020, 32'h0, MEM_COUNT_WORD, 0, 32'h0, MEM_CODE_READ), "rstmid_ld");
        run_vec(mk(0, 32'h010, 32'h0, MEM_COUNT_WORD, 0, 32'hbeef5aef, MEM_CODE_READ), "rstmid_if");

        // Idle: nothing requested, memory never written.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle_we%0d", i), 32'(mem_wr_en), 32'd0);
            chk($sformatf("idle_cnt%0d", i), 32'(mem_count), 32'(MEM_COUNT_NONE));
        end
        run_vec(mk(1, 32'h004, 32'h0, MEM_COUNT_WORD, 0, 32'h11223344, MEM_CODE_READ), "idle_ld");
        run_vec(mk(0, 32'h010, 32'h0, MEM_COUNT_WORD, 0, 32'hbeef5aef, MEM_CODE_READ), "idle_if");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
